// File: rtl/sig_scanner_pkg.sv
// Shared types, limits, mapper codes and configuration-packing helpers for
// the cartridge signature scanner.
package sig_scanner_pkg;

  // Scan sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_LANES     = 32;
  localparam int MAX_LEN_LIMIT = 8;

  // Standard 2600 bank-switching mapper codes.
  localparam logic [3:0] MAP_F8 = 4'd1;
  localparam logic [3:0] MAP_F6 = 4'd2;
  localparam logic [3:0] MAP_FE = 4'd3;
  localparam logic [3:0] MAP_E0 = 4'd4;
  localparam logic [3:0] MAP_3F = 4'd5;
  localparam logic [3:0] MAP_CV = 4'd9;
  localparam logic [3:0] MAP_E7 = 4'd12;

  // Place one pattern or mask byte for a lane (byte 0 is the oldest byte).
  function automatic logic [MAX_LANES*MAX_LEN_LIMIT*8-1:0] put_pat_byte(
    input logic [MAX_LANES*MAX_LEN_LIMIT*8-1:0] vec,
    input int lane, input int idx, input int max_len, input logic [7:0] value);
    logic [MAX_LANES*MAX_LEN_LIMIT*8-1:0] v;
    v = vec;
    v[(lane*max_len+idx)*8 +: 8] = value;
    return v;
  endfunction

  // Place a 4-bit per-lane field (signature length or mapper code).
  function automatic logic [MAX_LANES*4-1:0] put_nibble(
    input logic [MAX_LANES*4-1:0] vec, input int lane, input logic [3:0] value);
    logic [MAX_LANES*4-1:0] v;
    v = vec;
    v[lane*4 +: 4] = value;
    return v;
  endfunction

  // Place a per-lane match threshold of cnt_w bits.
  function automatic logic [MAX_LANES*8-1:0] put_need(
    input logic [MAX_LANES*8-1:0] vec, input int lane, input int cnt_w,
    input logic [7:0] value);
    logic [MAX_LANES*8-1:0] v;
    v = vec;
    for (int b = 0; b < 8; b++) begin
      if (b < cnt_w) v[lane*cnt_w+b] = value[b];
    end
    return v;
  endfunction

  // Mark lane 'lane' as suppressed whenever lane 'other' hits.
  function automatic logic [MAX_LANES*MAX_LANES-1:0] put_veto(
    input logic [MAX_LANES*MAX_LANES-1:0] vec, input int lane, input int other,
    input int num_lanes);
    logic [MAX_LANES*MAX_LANES-1:0] v;
    v = vec;
    v[lane*num_lanes+other] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sig_scanner_lane.sv
// One signature lane: masked comparison of the newest LEN window bytes,
// saturating match counter, sticky threshold hit and, when
// SIG_SCANNER_FIRSTADDR_EN is defined, the start address of the first match.
module sig_scanner_lane
  import sig_scanner_pkg::*;
#(
  parameter int                     MAX_LEN = 5,
  parameter int                     ADDR_W  = 20,
  parameter int                     CNT_W   = 4,
  parameter int                     LEN     = 1,
  parameter logic [MAX_LEN*8-1:0]   PAT     = '0,
  parameter logic [MAX_LEN*8-1:0]   MASK    = '1,
  parameter logic [CNT_W-1:0]       NEED    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [MAX_LEN*8-1:0] window,
  input  logic [3:0]           fill,
  input  logic [ADDR_W-1:0]    addr,
  output logic                 hit,
  output logic [ADDR_W-1:0]    first_addr
);

  localparam logic [4:0]       LEN_W   = 5'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_LEN-1:0] byte_ok_s;
  logic               match_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               hit_r;
  logic               unused_s;

  // Window age k (0 = newest) lines up with pattern byte LEN-1-k.
  for (genvar j = 0; j < MAX_LEN; j++) begin : g_byte
    if (j < LEN) begin : g_used
      assign byte_ok_s[j] =
        ((window[(LEN-1-j)*8 +: 8] ^ PAT[j*8 +: 8]) & MASK[j*8 +: 8]) == 8'h00;
    end else begin : g_unused
      assign byte_ok_s[j] = 1'b1;
    end
  end

  // A match needs enough bytes of this scan to cover the whole signature.
  assign match_s   = en & (&byte_ok_s) & (({1'b0, fill} + 5'd1) >= LEN_W);
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;
  assign unused_s  = ^{window, addr};

  // Saturating match counter and sticky threshold flag.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_r <= '0;
      hit_r <= 1'b0;
    end else if (match_s) begin
      cnt_r <= cnt_inc_s;
      if (cnt_inc_s == NEED) hit_r <= 1'b1;
    end
  end

  assign hit = hit_r;

`ifdef SIG_SCANNER_FIRSTADDR_EN
  logic [ADDR_W-1:0] first_addr_r;

  // Capture the first-byte address of this lane's first match (counter still zero).
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      first_addr_r <= '0;
    end else if (match_s && (cnt_r == '0)) begin
      first_addr_r <= addr - ADDR_W'(LEN - 1);
    end
  end

  assign first_addr = first_addr_r;
`else
  assign first_addr = '0;
`endif

endmodule

// File: rtl/sig_scanner.sv
// Streaming byte-signature scanner for cartridge images. Owns the byte
// history, fill count, scan FSM, veto masking and priority encoder; the
// per-signature work is done by sig_scanner_lane instances.
// Optional feature macro: SIG_SCANNER_FIRSTADDR_EN (per-lane first match address).
module sig_scanner
  import sig_scanner_pkg::*;
#(
  parameter int NUM_PATTERNS = 8,
  parameter int MAX_LEN      = 5,
  parameter int ADDR_W       = 20,
  parameter int CNT_W        = 4,
  parameter logic [NUM_PATTERNS*MAX_LEN*8-1:0]    PAT_BYTES = '0,
  parameter logic [NUM_PATTERNS*MAX_LEN*8-1:0]    PAT_MASK  = '1,
  parameter logic [NUM_PATTERNS*4-1:0]            PAT_LEN   = '0,
  parameter logic [NUM_PATTERNS*CNT_W-1:0]        PAT_NEED  = '0,
  parameter logic [NUM_PATTERNS*NUM_PATTERNS-1:0] PAT_VETO  = '0,
  parameter logic [NUM_PATTERNS*4-1:0]            PAT_CODE  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           byte_valid,
  input  logic [7:0]                     byte_data,
  input  logic [ADDR_W-1:0]              byte_addr,
  input  logic                           byte_last,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_PATTERNS-1:0]        hit_vec,
  output logic                           result_valid,
  output logic [3:0]                     result_code,
  output logic [NUM_PATTERNS*ADDR_W-1:0] first_addr
);

  localparam logic [3:0] FILL_MAX = 4'(MAX_LEN);

  state_t                       state_r, state_nx_s;
  logic [(MAX_LEN-1)*8-1:0]     hist_r;
  logic [3:0]                   fill_r;
  logic [MAX_LEN*8-1:0]         window_s;
  logic                         accept_s;
  logic [NUM_PATTERNS-1:0]      hit_s;
  logic [NUM_PATTERNS-1:0]      surv_s;
  logic [3:0]                   code_s;
  logic                         busy_r, done_r, result_valid_r;
  logic [3:0]                   result_code_r;

  // start wins over a byte presented in the same cycle.
  assign accept_s = (state_r == SCAN) & byte_valid & ~start;
  assign window_s = {hist_r, byte_data};

  // Byte history and fill count; both restart with every scan.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      hist_r <= '0;
      fill_r <= 4'd0;
    end else if (accept_s) begin
      hist_r <= window_s[(MAX_LEN-1)*8-1:0];
      if (fill_r != FILL_MAX) fill_r <= fill_r + 4'd1;
    end
  end

  for (genvar i = 0; i < NUM_PATTERNS; i++) begin : g_lane
    sig_scanner_lane #(
      .MAX_LEN (MAX_LEN),
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W),
      .LEN     (int'(PAT_LEN[i*4 +: 4])),
      .PAT     (PAT_BYTES[i*MAX_LEN*8 +: MAX_LEN*8]),
      .MASK    (PAT_MASK[i*MAX_LEN*8 +: MAX_LEN*8]),
      .NEED    (PAT_NEED[i*CNT_W +: CNT_W])
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .clr        (start),
      .en         (accept_s),
      .window     (window_s),
      .fill       (fill_r),
      .addr       (byte_addr),
      .hit        (hit_s[i]),
      .first_addr (first_addr[i*ADDR_W +: ADDR_W])
    );
  end

  // Veto masking, then lowest-index surviving lane selects the mapper code.
  always_comb begin
    surv_s = '0;
    code_s = 4'd0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      surv_s[i] = hit_s[i] & ~(|(PAT_VETO[i*NUM_PATTERNS +: NUM_PATTERNS] & hit_s));
    end
    for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
      code_s = surv_s[i] ? PAT_CODE[i*4 +: 4] : code_s;
    end
  end

  // Next-state logic; start rearms the scan from any state.
  always_comb begin
    state_nx_s = state_r;
    if (start) begin
      state_nx_s = SCAN;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = IDLE;
        SCAN:    state_nx_s = (byte_valid && byte_last) ? FINAL : SCAN;
        FINAL:   state_nx_s = DONE;
        DONE:    state_nx_s = DONE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State register, registered status flags and the latched result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      result_valid_r <= 1'b0;
      result_code_r  <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == SCAN) || (state_nx_s == FINAL);
      done_r  <= (state_nx_s == DONE);
      if (start) begin
        result_valid_r <= 1'b0;
        result_code_r  <= 4'd0;
      end else if (state_r == FINAL) begin
        result_valid_r <= |surv_s;
        result_code_r  <= code_s;
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign hit_vec      = hit_s;
  assign result_valid = result_valid_r;
  assign result_code  = result_code_r;

endmodule
